deser_queue: RTL

Parametrised serial-to-parallel receive queue for the LaserDrop receive path. It assembles `WIDTH`-bit words from a gated serial bit stream, with bit order selectable per word. Completed words are buffered in a `DEPTH`-entry first-word-fall-through FIFO and presented on a valid/ready handshake. It supersedes the single-word shift-register queue: it adds multi-word buffering, bit-order selection, overrun detection, flush and optional per-word parity.

---
 rtl/deser_pkg.sv | 10 +
 rtl/word_fifo.sv | 58 +++++
 rtl/deser_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// deser_pkg: FSM state type and pointer/count width helper shared by the receive queue
package deser_pkg;
  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: first-word-fall-through storage with wrapping pointers and a saturating-free occupancy count
module word_fifo
  import deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        head,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next storage, pointers and occupancy; flush empties everything
  always_comb begin
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d = '0;
      wr_d = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  // storage and pointer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = (cnt_q == '0) ? '0 : mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/deser_queue.sv
// deser_queue: serial-to-parallel receive queue; define DESER_PARITY_EN for a trailing even-parity bit per word
module deser_queue
  import deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    msb_first,
  input  logic                    flush,
  input  logic                    clear_err,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [cnt_w(DEPTH)-1:0] count,
`ifdef DESER_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    overrun
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = cnt_w(DEPTH);
  logic [IW-1:0] bit_idx_q, bit_idx_d, pos;
  logic [WIDTH-1:0] shreg_q, shreg_d, word, push_word;
  logic msb_q, msb_d, ord, take, last, complete, par_bad, pop, push;
  logic overrun_q, overrun_d;
`ifdef DESER_PARITY_EN
  state_e state_q, state_d;
  logic par_q, par_d, parity_err_q, parity_err_d;
`endif
  // place the sampled bit, advance the word FSM and derive push/drop/error events
  always_comb begin
    take = bit_valid & ~flush;
    last = bit_idx_q == IW'(WIDTH - 1);
    ord = (bit_idx_q == '0) ? msb_first : msb_q;
    pos = ord ? IW'(WIDTH - 1) - bit_idx_q : bit_idx_q;
    word = (bit_idx_q == '0) ? '0 : shreg_q;
    word[pos] = bit_in;
    bit_idx_d = flush ? '0 : bit_idx_q;
    shreg_d = shreg_q;
    msb_d = msb_q;
    complete = 1'b0;
    par_bad = 1'b0;
    push_word = word;
`ifdef DESER_PARITY_EN
    state_d = flush ? COLLECT : state_q;
    par_d = par_q;
    if (take && state_q == PARITY) begin
      complete = 1'b1;
      par_bad = par_q ^ bit_in;
      push_word = shreg_q;
      state_d = COLLECT;
    end else if (take) begin
      msb_d = ord;
      shreg_d = word;
      par_d = (bit_idx_q == '0) ? bit_in : par_q ^ bit_in;
      bit_idx_d = last ? '0 : bit_idx_q + 1'b1;
      state_d = last ? PARITY : COLLECT;
    end
`else
    if (take) begin
      msb_d = ord;
      shreg_d = word;
      complete = last;
      bit_idx_d = last ? '0 : bit_idx_q + 1'b1;
    end
`endif
    pop = out_valid & out_ready & ~flush;
    push = complete & ~par_bad & ((count != CW'(DEPTH)) | pop);
    overrun_d = (overrun_q & ~clear_err) | (complete & ~par_bad & ~push);
`ifdef DESER_PARITY_EN
    parity_err_d = (parity_err_q & ~clear_err) | (complete & par_bad);
`endif
  end
  // word-assembly state and sticky error flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_idx_q <= '0;
      shreg_q <= '0;
      msb_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
      state_q <= COLLECT;
      par_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      bit_idx_q <= bit_idx_d;
      shreg_q <= shreg_d;
      msb_q <= msb_d;
      overrun_q <= overrun_d;
`ifdef DESER_PARITY_EN
      state_q <= state_d;
      par_q <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end
  word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wdata(push_word),
    .head(out_data),
    .count(count)
  );
  assign out_valid = count != '0;
  assign overrun = overrun_q;
`ifdef DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif
endmodule
